// File: rtl/nal_packetizer_if.sv
// Byte-stream handshake bundle for the NAL packetizer: start request, payload in, Annex-B out.
// The slave modport is the packetizer; the master modport is the surrounding logic.
interface nal_packetizer_if;
    logic       nal_start;
    logic [7:0] nal_type_in;
    logic       start_ready;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       pay_last;
    logic       pay_ready;
    logic [7:0] bs_data;
    logic       bs_valid;
    logic       bs_ready;

    modport master (
        output nal_start, nal_type_in, pay_data, pay_valid, pay_last, bs_ready,
        input  start_ready, pay_ready, bs_data, bs_valid
    );

    modport slave (
        input  nal_start, nal_type_in, pay_data, pay_valid, pay_last, bs_ready,
        output start_ready, pay_ready, bs_data, bs_valid
    );
endinterface

// File: rtl/nal_packetizer.sv
// Annex-B NAL writer: start code, header byte, then payload with emulation-prevention bytes.
// A single registered output byte feeds the downstream valid/ready consumer.
module nal_packetizer #(
    parameter int unsigned MAX_PAYLOAD_BYTES = 383,
    parameter int unsigned CNT_WIDTH         = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nal_packetizer_if.slave      bus,
    output logic                 nal_done,
    output logic [CNT_WIDTH-1:0] nal_bytes,
    output logic [7:0]           epb_count,
    output logic                 error_overflow
);

    typedef enum logic [3:0] {
        StIdle, StSc1, StSc2, StSc3, StHdr, StPayload, StEpb, StTrailEpb, StFlush
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           type_q, type_d;
    logic [7:0]           bs_data_q, bs_data_d;
    logic                 bs_valid_q, bs_valid_d;
    logic [1:0]           zero_run_q, zero_run_d;
    logic [CNT_WIDTH-1:0] pay_cnt_q, pay_cnt_d;
    logic [CNT_WIDTH-1:0] nal_bytes_q, nal_bytes_d;
    logic [7:0]           epb_q, epb_d;
    logic                 ovf_q, ovf_d;

    logic can_load, load, count_byte, count_epb, dropping, need_epb;

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        bs_data_d   = bs_data_q;
        zero_run_d  = zero_run_q;
        pay_cnt_d   = pay_cnt_q;
        nal_bytes_d = nal_bytes_q;
        epb_d       = epb_q;
        ovf_d       = ovf_q;
        load        = 1'b0;
        count_byte  = 1'b0;
        count_epb   = 1'b0;
        nal_done    = 1'b0;
        bus.pay_ready = 1'b0;

        can_load = !bs_valid_q || bus.bs_ready;
        dropping = pay_cnt_q >= CNT_WIDTH'(MAX_PAYLOAD_BYTES);
        need_epb = bus.pay_valid && !dropping && (zero_run_q == 2'd2) && (bus.pay_data <= 8'h03);

        unique case (state_q)
            StIdle: begin
                // Output register is always empty here, so the first 00 loads on accept.
                if (bus.nal_start) begin
                    load        = 1'b1;
                    bs_data_d   = 8'h00;
                    type_d      = bus.nal_type_in;
                    zero_run_d  = 2'd0;
                    pay_cnt_d   = '0;
                    nal_bytes_d = '0;
                    epb_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = StSc1;
                end
            end
            StSc1: if (can_load) begin
                load = 1'b1; bs_data_d = 8'h00; state_d = StSc2;
            end
            StSc2: if (can_load) begin
                load = 1'b1; bs_data_d = 8'h00; state_d = StSc3;
            end
            StSc3: if (can_load) begin
                load = 1'b1; bs_data_d = 8'h01; state_d = StHdr;
            end
            StHdr: if (can_load) begin
                load       = 1'b1;
                bs_data_d  = type_q;
                count_byte = 1'b1;
                zero_run_d = 2'd0;
                state_d    = StPayload;
            end
            StPayload: begin
                if (dropping) begin
                    // Past the buffer limit: swallow bytes, trailing EPB follows the last emitted one.
                    bus.pay_ready = 1'b1;
                    if (bus.pay_valid) begin
                        ovf_d = 1'b1;
                        if (bus.pay_last) state_d = (zero_run_q != 2'd0) ? StTrailEpb : StFlush;
                    end
                end else begin
                    bus.pay_ready = can_load && !need_epb;
                    if (need_epb) begin
                        state_d = StEpb;
                    end else if (bus.pay_valid && can_load) begin
                        load       = 1'b1;
                        bs_data_d  = bus.pay_data;
                        count_byte = 1'b1;
                        pay_cnt_d  = pay_cnt_q + 1'b1;
                        if (bus.pay_data == 8'h00) begin
                            zero_run_d = (zero_run_q == 2'd2) ? 2'd2 : zero_run_q + 2'd1;
                        end else begin
                            zero_run_d = 2'd0;
                        end
                        if (bus.pay_last) begin
                            state_d = (bus.pay_data == 8'h00) ? StTrailEpb : StFlush;
                        end
                    end
                end
            end
            StEpb, StTrailEpb: if (can_load) begin
                load       = 1'b1;
                bs_data_d  = 8'h03;
                count_byte = 1'b1;
                count_epb  = 1'b1;
                zero_run_d = 2'd0;
                state_d    = (state_q == StEpb) ? StPayload : StFlush;
            end
            StFlush: if (can_load) begin
                nal_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (count_byte && !(&nal_bytes_q)) nal_bytes_d = nal_bytes_q + 1'b1;
        if (count_epb && !(&epb_q)) epb_d = epb_q + 8'd1;

        if (load) begin
            bs_valid_d = 1'b1;
        end else if (bus.bs_ready) begin
            bs_valid_d = 1'b0;
        end else begin
            bs_valid_d = bs_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            type_q      <= 8'h00;
            bs_data_q   <= 8'h00;
            bs_valid_q  <= 1'b0;
            zero_run_q  <= 2'd0;
            pay_cnt_q   <= '0;
            nal_bytes_q <= '0;
            epb_q       <= 8'h00;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            bs_data_q   <= bs_data_d;
            bs_valid_q  <= bs_valid_d;
            zero_run_q  <= zero_run_d;
            pay_cnt_q   <= pay_cnt_d;
            nal_bytes_q <= nal_bytes_d;
            epb_q       <= epb_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.start_ready = (state_q == StIdle);
    assign bus.bs_data     = bs_data_q;
    assign bus.bs_valid    = bs_valid_q;
    assign nal_bytes       = nal_bytes_q;
    assign epb_count       = epb_q;
    assign error_overflow  = ovf_q;

endmodule
